// File: rtl/shared_bus_pkg.sv
// Shared declarations for the shared bus controller.
//   state_t          : controller FSM states
//   OWNER_0/OWNER_1  : encodings of the current bus owner
//   DEF_*            : default parameter values
package shared_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_BURST_LEN = 4;
  localparam int unsigned DEF_TIMEOUT   = 16;

endpackage : shared_bus_pkg

// File: rtl/xfer_watchdog.sv
// Burst watchdog: counts consecutive stalled transfer cycles.
// Used only when SHARED_BUS_TIMEOUT_EN is defined.
//   clk, reset : clock, async active-low reset
//   tick       : a transfer cycle passed without an accepted word
//   clear      : restart the count (word accepted or not transferring)
//   expired    : combinational, this tick is the TIMEOUT-th stalled cycle
module xfer_watchdog
  import shared_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Count holds the stalls already seen, so the current tick is number cnt_q+1.
  assign expired = tick && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule : xfer_watchdog

// File: rtl/shared_bus_ctrl.sv
// Shared bus controller: moves a fixed-length burst from the granted client
// onto a single registered output bus, and signals completion or abort.
// Optional macro SHARED_BUS_TIMEOUT_EN adds a stall watchdog (xfer_watchdog).
//   clk, reset          : clock, async active-low reset
//   grant_0/grant_1     : arbiter grants
//   date_x/valid_x      : client data words and valids
//   ack_0/ack_1         : combinational word-accept to each client
//   done_0/done_1       : one-cycle burst-complete pulse to the owner
//   bus_data/valid/src  : registered shared bus word, strobe and owner
//   abort               : one-cycle pulse, burst terminated early
//   grant_err           : sticky, both grants seen together in IDLE
module shared_bus_ctrl
  import shared_bus_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grant_0,
  input  logic             grant_1,
  input  logic [WIDTH-1:0] date_0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] date_1,
  input  logic             valid_1,
  output logic             ack_0,
  output logic             ack_1,
  output logic             done_0,
  output logic             done_1,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_valid,
  output logic             bus_src,
  output logic             abort,
  output logic             grant_err
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   bus_data_q, bus_data_d;
  logic               bus_valid_q, bus_valid_d;
  logic               bus_src_q, bus_src_d;
  logic               done_0_q, done_0_d;
  logic               done_1_q, done_1_d;
  logic               abort_q, abort_d;
  logic               grant_err_q, grant_err_d;

  logic               grant_own, valid_own, in_xfer, accept_c, wd_expired;
  logic [WIDTH-1:0]   date_own;

  // Owner-side view of the client interface; the non-owner is ignored.
  assign grant_own = (owner_q == OWNER_1) ? grant_1 : grant_0;
  assign valid_own = (owner_q == OWNER_1) ? valid_1 : valid_0;
  assign date_own  = (owner_q == OWNER_1) ? date_1  : date_0;
  assign in_xfer   = (state_q == XFER);
  assign accept_c  = in_xfer && grant_own && valid_own;

  assign ack_0 = accept_c && (owner_q == OWNER_0);
  assign ack_1 = accept_c && (owner_q == OWNER_1);

`ifdef SHARED_BUS_TIMEOUT_EN
  // Stalls are counted only inside XFER; entering XFER starts from zero.
  xfer_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .tick    (in_xfer && !accept_c),
    .clear   (!in_xfer || accept_c),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    count_d     = count_q;
    bus_data_d  = bus_data_q;
    bus_valid_d = 1'b0;
    bus_src_d   = bus_src_q;
    done_0_d    = 1'b0;
    done_1_d    = 1'b0;
    abort_d     = 1'b0;
    grant_err_d = grant_err_q;

    unique case (state_q)
      IDLE: begin
        if (grant_0) begin
          owner_d = OWNER_0;
          count_d = '0;
          state_d = XFER;
          if (grant_1) grant_err_d = 1'b1;
        end else if (grant_1) begin
          owner_d = OWNER_1;
          count_d = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (!grant_own || wd_expired) begin
          abort_d = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end else if (accept_c) begin
          bus_data_d  = date_own;
          bus_valid_d = 1'b1;
          bus_src_d   = owner_q;
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = DONE;
            // Registered so the pulse is visible exactly while in DONE.
            if (owner_q == OWNER_1) done_1_d = 1'b1;
            else                    done_0_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_0;
      count_q     <= '0;
      bus_data_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= 1'b0;
      done_0_q    <= 1'b0;
      done_1_q    <= 1'b0;
      abort_q     <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      count_q     <= count_d;
      bus_data_q  <= bus_data_d;
      bus_valid_q <= bus_valid_d;
      bus_src_q   <= bus_src_d;
      done_0_q    <= done_0_d;
      done_1_q    <= done_1_d;
      abort_q     <= abort_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign bus_data  = bus_data_q;
  assign bus_valid = bus_valid_q;
  assign bus_src   = bus_src_q;
  assign done_0    = done_0_q;
  assign done_1    = done_1_q;
  assign abort     = abort_q;
  assign grant_err = grant_err_q;

endmodule : shared_bus_ctrl

// File: doc/shared_bus_ctrl.md
Name: shared_bus_ctrl

Overview:
- Sits directly downstream of the two-client arbiter (cerere_0/cerere_1 -> grant_0/grant_1) and consumes its grants.
- When a client is granted, the block moves a fixed-length burst of words from that client onto a single shared output bus.
- At burst end it pulses done to the owner, which then drops its cerere so the arbiter can re-arbitrate.

Parameters:
- WIDTH, 8, data word width of clients and bus.
- BURST_LEN, 4, words per burst (>=1).
- TIMEOUT, 16, idle cycles tolerated inside a burst; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- grant_0  input  1  arbiter grant for client 0.
- grant_1  input  1  arbiter grant for client 1.
- date_0  input  WIDTH  client 0 data word.
- valid_0  input  1  client 0 word valid.
- date_1  input  WIDTH  client 1 data word.
- valid_1  input  1  client 1 word valid.
- ack_0  output  1  client 0 word accepted this cycle (combinational).
- ack_1  output  1  client 1 word accepted this cycle (combinational).
- done_0  output  1  one-cycle pulse: client 0 burst complete.
- done_1  output  1  one-cycle pulse: client 1 burst complete.
- bus_data  output  WIDTH  registered shared bus data.
- bus_valid  output  1  registered bus word strobe.
- bus_src  output  1  registered owner of the current bus word.
- abort  output  1  one-cycle pulse: burst terminated early.
- grant_err  output  1  sticky flag: both grants seen high together.

Behaviour:
- Reset (reset==0, async): state=IDLE, owner=0, count=0, all outputs 0, grant_err=0.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - grant_0 -> owner=0, count=0, go XFER.
  - else grant_1 -> owner=1, count=0, go XFER.
  - Both grants high -> client 0 wins and grant_err sets (sticky until reset).
- XFER:
  - Word accepted when valid_owner && grant_owner.
  - ack_owner is asserted combinationally in that cycle; ack of the non-owner is always 0.
  - On accept: next cycle bus_data=date_owner, bus_valid=1, bus_src=owner; count+1.
  - Latency is 1 cycle from accept to bus.
  - No accept -> bus_valid=0 next cycle; bus_data holds its last value.
  - Accept with count==BURST_LEN-1 -> go DONE, count=0.
  - grant_owner low in any XFER cycle -> no accept that cycle, abort pulses next cycle, go IDLE, no done.
- DONE: done_owner=1 for exactly this one cycle, then IDLE unconditionally. Grants are ignored in DONE.
- Minimum spacing between bursts: DONE + IDLE = 2 cycles after the last accepted word.
- The non-owner's valid and date are ignored throughout a burst.
- count width is clog2(BURST_LEN), minimum 1. BURST_LEN=1 means the first accept goes straight to DONE.
- Reset mid-burst: immediate return to reset values. The partial burst is lost, with no done and no abort.

Optional Feature:
- Macro: SHARED_BUS_TIMEOUT_EN.
- Defined:
  - A watchdog counts consecutive XFER cycles without an accept and clears on each accept.
  - When it reaches TIMEOUT, abort pulses next cycle and the FSM goes IDLE.
  - The counter resets on entering XFER.
- Undefined: no watchdog logic; a burst waits indefinitely for valid while grant holds.

Decomposition:
- Package shared_bus_pkg holds:
  - state enum (IDLE, XFER, DONE);
  - owner constants OWNER_0=0, OWNER_1=1;
  - default-parameter localparams.
- Sub-module xfer_watchdog (tick, clear, expired; TIMEOUT parameter) is instantiated only under SHARED_BUS_TIMEOUT_EN. All other logic stays in one module.

Test Plan (WIDTH=8, BURST_LEN=4):
- Reset held 100 ns with grants and valids toggling -> all outputs stay 0. Release -> IDLE.
- grant_0=1, valid_0=1 continuously, date_0=0x10..0x13 -> bus_valid for 4 consecutive cycles, data 0x10..0x13, bus_src=0; done_0 pulses 1 cycle after the last word; ack_1 stays 0.
- grant_1=1, valid_1 high only on alternate cycles, date_1=0xA0..0xA3 -> 4 words with gaps; bus_valid=0 in gap cycles; done_1 pulses after 0xA3.
- grant_0 drops after 2 accepted words -> abort pulses once, no done_0. A new grant_1 starts a fresh burst with count=0.
- grant_0 and grant_1 both high in IDLE -> owner=0 and grant_err=1, staying 1 through later bursts until reset.
- With SHARED_BUS_TIMEOUT_EN, TIMEOUT=16: grant_0 held, valid_0=0 after 1 word -> abort exactly 17 cycles after that accept, then IDLE.
